// File: rtl/aq_axis_arb_pkg.sv
// Shared types and constants for the packet arbiter.
// No logic; state encoding, counter width and a constant clog2 helper.
package aq_axis_arb_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_XFER = 1'b1
    } state_t;

    localparam int PKT_CNT_W = 32;

    function automatic int clog2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) begin
            r++;
        end
        return r;
    endfunction

endpackage

// File: rtl/aq_rr_pick.sv
// Round-robin picker: first set req bit strictly after 'last', wrapping modulo N.
// Latency: purely combinational.
// Backpressure: none; found is low when no bit of req is set.
module aq_rr_pick
    import aq_axis_arb_pkg::*;
#(
    parameter int N    = 4,
    parameter int ID_W = 2
) (
    input  logic [N-1:0]    req,
    input  logic [ID_W-1:0] last,
    output logic            found,
    output logic [ID_W-1:0] idx
);

    // Sum of start offset and winner offset reaches 2N-1; keep headroom for idx slicing too.
    localparam int SW = ((clog2(2 * N) > ID_W) ? clog2(2 * N) : ID_W) + 1;
    localparam logic [SW-1:0] N_L = SW'(N);

    logic [SW-1:0] w_start;
    logic [N-1:0]  w_rot;
    logic [SW-1:0] w_off;
    logic [SW-1:0] w_sum;

    assign w_start = SW'(last) + SW'(1);
    assign w_rot   = N'({req, req} >> w_start);

    always_comb begin
        found = 1'b0;
        w_off = '0;
        for (int k = N - 1; k >= 0; k--) begin
            if (w_rot[k]) begin
                found = 1'b1;
                w_off = SW'(k);
            end
        end
    end

    assign w_sum = w_start + w_off;
    assign idx   = (w_sum >= N_L) ? ID_W'(w_sum - N_L) : ID_W'(w_sum);

endmodule

// File: rtl/aq_axis_pkt_arbiter.sv
// Packet-level round-robin arbiter feeding the FIFO write port from N_SRC AXI-Stream sources.
// Latency: 1 arbitration cycle per packet, then zero-latency combinational pass-through.
// Backpressure: M_AXIS_TREADY routed to the granted source only; almost-full blocks new grants.
module aq_axis_pkt_arbiter
    import aq_axis_arb_pkg::*;
#(
    parameter int N_SRC = 4,
    parameter int WIDTH = 64,
    parameter int ID_W  = 2
) (
    input  logic                   ACLK,
    input  logic                   RST,
    input  logic [N_SRC-1:0]       SRC_ENA,
    input  logic [N_SRC-1:0]       S_AXIS_TVALID,
    output logic [N_SRC-1:0]       S_AXIS_TREADY,
    input  logic [N_SRC-1:0]       S_AXIS_TLAST,
    input  logic [N_SRC*WIDTH-1:0] S_AXIS_TDATA,
    output logic                   M_AXIS_TVALID,
    input  logic                   M_AXIS_TREADY,
    output logic                   M_AXIS_TLAST,
    output logic [WIDTH-1:0]       M_AXIS_TDATA,
    output logic [ID_W-1:0]        M_AXIS_TID,
    input  logic                   FIFO_ALM_FULL,
    output logic                   BUSY,
    output logic [PKT_CNT_W-1:0]   PKT_COUNT
);

    state_t                 r_state;
    logic [ID_W-1:0]        r_gnt;
    logic [ID_W-1:0]        r_last;
    logic [PKT_CNT_W-1:0]   r_pkt_count;

    logic [N_SRC-1:0]       w_req;
    logic                   w_found;
    logic [ID_W-1:0]        w_win;
    logic                   w_busy;
    logic                   w_sel_vld;
    logic                   w_sel_last;
    logic                   w_beat_last;
    logic [WIDTH-1:0]       w_src_dat [N_SRC];

    always_comb begin
        for (int i = 0; i < N_SRC; i++) begin
            w_src_dat[i] = S_AXIS_TDATA[i*WIDTH +: WIDTH];
        end
    end

    assign w_req = S_AXIS_TVALID & SRC_ENA;

    aq_rr_pick #(
        .N    (N_SRC),
        .ID_W (ID_W)
    ) u_pick (
        .req   (w_req),
        .last  (r_last),
        .found (w_found),
        .idx   (w_win)
    );

    // Every output is gated by BUSY so nothing from an unselected source leaks in IDLE.
    assign w_busy      = (r_state == ST_XFER);
    assign w_sel_vld   = w_busy & S_AXIS_TVALID[r_gnt];
    assign w_sel_last  = w_busy & S_AXIS_TLAST[r_gnt];
    assign w_beat_last = w_sel_vld & M_AXIS_TREADY & w_sel_last;

    assign M_AXIS_TVALID = w_sel_vld;
    assign M_AXIS_TLAST  = w_sel_last;
    assign M_AXIS_TDATA  = w_busy ? w_src_dat[r_gnt] : '0;
    assign M_AXIS_TID    = r_gnt;
    assign S_AXIS_TREADY = w_busy ? (N_SRC'(M_AXIS_TREADY) << r_gnt) : '0;
    assign BUSY          = w_busy;
    assign PKT_COUNT     = r_pkt_count;

    always_ff @(posedge ACLK) begin
        if (RST) begin
            r_state     <= ST_IDLE;
            r_gnt       <= '0;
            r_last      <= ID_W'(N_SRC - 1);
            r_pkt_count <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_found && !FIFO_ALM_FULL) begin
                        r_gnt   <= w_win;
                        r_last  <= w_win;
                        r_state <= ST_XFER;
                    end
                end
                ST_XFER: begin
                    if (w_beat_last) begin
                        r_state     <= ST_IDLE;
                        r_pkt_count <= r_pkt_count + 1'b1;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_aq_axis_pkt_arbiter.sv
// Bench for aq_axis_pkt_arbiter: per-source packet queues, an offline round-robin
// ordering model and a beat-by-beat scoreboard on the master side.
module tb_aq_axis_pkt_arbiter;

    localparam int N_SRC = 4;
    localparam int WIDTH = 64;
    localparam int ID_W  = 2;
    localparam int BW    = WIDTH + 1;
    localparam int EW    = ID_W + 1 + WIDTH;

    logic                   ACLK;
    logic                   RST;
    logic [N_SRC-1:0]       SRC_ENA;
    logic [N_SRC-1:0]       S_AXIS_TVALID;
    logic [N_SRC-1:0]       S_AXIS_TREADY;
    logic [N_SRC-1:0]       S_AXIS_TLAST;
    logic [N_SRC*WIDTH-1:0] S_AXIS_TDATA;
    logic                   M_AXIS_TVALID;
    logic                   M_AXIS_TREADY;
    logic                   M_AXIS_TLAST;
    logic [WIDTH-1:0]       M_AXIS_TDATA;
    logic [ID_W-1:0]        M_AXIS_TID;
    logic                   FIFO_ALM_FULL;
    logic                   BUSY;
    logic [31:0]            PKT_COUNT;

    aq_axis_pkt_arbiter #(
        .N_SRC (N_SRC),
        .WIDTH (WIDTH),
        .ID_W  (ID_W)
    ) dut (
        .ACLK          (ACLK),
        .RST           (RST),
        .SRC_ENA       (SRC_ENA),
        .S_AXIS_TVALID (S_AXIS_TVALID),
        .S_AXIS_TREADY (S_AXIS_TREADY),
        .S_AXIS_TLAST  (S_AXIS_TLAST),
        .S_AXIS_TDATA  (S_AXIS_TDATA),
        .M_AXIS_TVALID (M_AXIS_TVALID),
        .M_AXIS_TREADY (M_AXIS_TREADY),
        .M_AXIS_TLAST  (M_AXIS_TLAST),
        .M_AXIS_TDATA  (M_AXIS_TDATA),
        .M_AXIS_TID    (M_AXIS_TID),
        .FIFO_ALM_FULL (FIFO_ALM_FULL),
        .BUSY          (BUSY),
        .PKT_COUNT     (PKT_COUNT)
    );

    // Source beat queues hold {last, data}; expected beats hold {tid, last, data}.
    logic [BW-1:0]   src_q [N_SRC][$];
    logic [EW-1:0]   exp_q [$];
    int              beat_tid [$];
    int              beat_cyc [$];
    int              checks;
    int              passes;
    int              cyc;
    bit              rnd;
    logic [ID_W-1:0] mdl_last;
    logic [31:0]     mdl_cnt;

    initial begin
        ACLK = 1'b0;
        forever #5 ACLK = ~ACLK;
    end

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached, passed=%0d total=%0d", passes, checks);
        $fatal(1);
    end

    task automatic drive_srcs();
        logic [BW-1:0] b;
        for (int i = 0; i < N_SRC; i++) begin
            if (src_q[i].size() > 0) begin
                b = src_q[i][0];
                S_AXIS_TVALID[i] = 1'b1;
                S_AXIS_TLAST[i]  = b[WIDTH];
                S_AXIS_TDATA[i*WIDTH +: WIDTH] = b[WIDTH-1:0];
            end else begin
                S_AXIS_TVALID[i] = 1'b0;
                S_AXIS_TLAST[i]  = 1'($urandom_range(0, 1));
                S_AXIS_TDATA[i*WIDTH +: WIDTH] = {$urandom, $urandom};
            end
        end
    endtask

    task automatic add_pkt(input int src, input int nbeats, input logic [WIDTH-1:0] base);
        for (int k = 0; k < nbeats; k++) begin
            src_q[src].push_back({(k == nbeats - 1), base + WIDTH'(k)});
        end
    endtask

    // Offline ordering: repeatedly pick the first non-empty source after the last winner.
    task automatic build_expected();
        logic [BW-1:0] tmp [N_SRC][$];
        logic [BW-1:0] b;
        int            p;
        bit            any;
        for (int i = 0; i < N_SRC; i++) tmp[i] = src_q[i];
        any = 1'b1;
        while (any) begin
            any = 1'b0;
            p   = 0;
            for (int k = 1; k <= N_SRC; k++) begin
                int j;
                j = (int'(mdl_last) + k) % N_SRC;
                if (!any && tmp[j].size() > 0) begin
                    any = 1'b1;
                    p   = j;
                end
            end
            if (any) begin
                do begin
                    b = tmp[p].pop_front();
                    exp_q.push_back({ID_W'(p), b});
                end while (!b[WIDTH] && tmp[p].size() > 0);
                mdl_last = ID_W'(p);
                mdl_cnt  = mdl_cnt + 32'd1;
            end
        end
    endtask

    task automatic expect_src(input int src);
        foreach (src_q[src][k]) begin
            exp_q.push_back({ID_W'(src), src_q[src][k]});
            if (src_q[src][k][WIDTH]) mdl_cnt = mdl_cnt + 32'd1;
        end
        mdl_last = ID_W'(src);
    endtask

    function automatic bit all_done();
        bit d;
        d = (exp_q.size() == 0) && (BUSY === 1'b0);
        for (int i = 0; i < N_SRC; i++) if (src_q[i].size() != 0) d = 1'b0;
        return d;
    endfunction

    // One clock: monitor at the falling edge, then update sources just after the rising edge.
    task automatic step();
        logic [N_SRC-1:0] fire;
        logic [N_SRC-1:0] exp_rdy;
        logic [EW-1:0]    e;
        @(negedge ACLK);
        if (M_AXIS_TVALID === 1'b1 && M_AXIS_TREADY === 1'b1) begin
            checks++;
            if (exp_q.size() == 0) begin
                $display("FAIL extra_beat: got tid=%0d data=%h, expected no beat", M_AXIS_TID, M_AXIS_TDATA);
            end else begin
                e = exp_q.pop_front();
                if ({M_AXIS_TID, M_AXIS_TLAST, M_AXIS_TDATA} !== e)
                    $display("FAIL beat: got tid=%0d last=%0b data=%h, want tid=%0d last=%0b data=%h",
                             M_AXIS_TID, M_AXIS_TLAST, M_AXIS_TDATA,
                             e[EW-1 -: ID_W], e[WIDTH], e[WIDTH-1:0]);
                else
                    passes++;
            end
            beat_tid.push_back(int'(M_AXIS_TID));
            beat_cyc.push_back(cyc);
        end
        exp_rdy = (BUSY === 1'b1) ? (N_SRC'(M_AXIS_TREADY) << M_AXIS_TID) : '0;
        checks++;
        if (S_AXIS_TREADY !== exp_rdy ||
            (BUSY !== 1'b1 && {M_AXIS_TVALID, M_AXIS_TLAST, M_AXIS_TDATA} !== '0))
            $display("FAIL ready_idle: tready=%b busy=%b mvalid=%b mlast=%b mdata=%h, want tready=%b and zero outputs when idle",
                     S_AXIS_TREADY, BUSY, M_AXIS_TVALID, M_AXIS_TLAST, M_AXIS_TDATA, exp_rdy);
        else
            passes++;
        fire = S_AXIS_TVALID & S_AXIS_TREADY;
        @(posedge ACLK);
        #1;
        for (int i = 0; i < N_SRC; i++) begin
            if (fire[i] && src_q[i].size() > 0) void'(src_q[i].pop_front());
        end
        cyc++;
        if (rnd) begin
            M_AXIS_TREADY = ($urandom_range(0, 3) != 0);
            FIFO_ALM_FULL = ($urandom_range(0, 3) == 0);
        end
        drive_srcs();
    endtask

    task automatic run_to_empty(input int budget, input string name);
        int n;
        n = 0;
        while (!all_done() && n < budget) begin
            step();
            n++;
        end
        checks++;
        if (!all_done())
            $display("FAIL %s_timeout: not drained after %0d cycles, %0d beats outstanding", name, n, exp_q.size());
        else
            passes++;
    endtask

    task automatic do_reset();
        RST           = 1'b1;
        SRC_ENA       = '1;
        M_AXIS_TREADY = 1'b1;
        FIFO_ALM_FULL = 1'b0;
        rnd           = 1'b0;
        for (int i = 0; i < N_SRC; i++) src_q[i].delete();
        exp_q.delete();
        beat_tid.delete();
        beat_cyc.delete();
        drive_srcs();
        repeat (2) @(posedge ACLK);
        #1;
        RST      = 1'b0;
        mdl_last = ID_W'(N_SRC - 1);
        mdl_cnt  = 32'd0;
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if (BUSY !== 1'b0) $display("FAIL reset_busy: got %b want 0", BUSY); else passes++;
        checks++;
        if (S_AXIS_TREADY !== '0) $display("FAIL reset_tready: got %b want 0", S_AXIS_TREADY); else passes++;
        checks++;
        if ({M_AXIS_TVALID, M_AXIS_TLAST} !== 2'b00)
            $display("FAIL reset_mvalid: got valid=%b last=%b want 0", M_AXIS_TVALID, M_AXIS_TLAST);
        else passes++;
        checks++;
        if (M_AXIS_TDATA !== '0) $display("FAIL reset_mdata: got %h want 0", M_AXIS_TDATA); else passes++;
        checks++;
        if (M_AXIS_TID !== '0) $display("FAIL reset_tid: got %0d want 0", M_AXIS_TID); else passes++;
        checks++;
        if (PKT_COUNT !== 32'd0) $display("FAIL reset_count: got %0d want 0", PKT_COUNT); else passes++;
    endtask

    task automatic test_single_src();
        int c0;
        do_reset();
        add_pkt(2, 3, 64'h10);
        build_expected();
        drive_srcs();
        c0 = cyc;
        step();
        checks++;
        if (BUSY !== 1'b1 || M_AXIS_TID !== 2'd2)
            $display("FAIL single_grant: got busy=%b tid=%0d want busy=1 tid=2", BUSY, M_AXIS_TID);
        else passes++;
        repeat (3) step();
        checks++;
        if (beat_cyc.size() != 3 || beat_cyc[0] - c0 != 1 || beat_cyc[1] - c0 != 2 || beat_cyc[2] - c0 != 3)
            $display("FAIL single_timing: got %0d beats, first at offset %0d, want 3 beats at offsets 1..3",
                     beat_cyc.size(), (beat_cyc.size() > 0) ? beat_cyc[0] - c0 : -1);
        else passes++;
        checks++;
        if (BUSY !== 1'b0 || PKT_COUNT !== mdl_cnt)
            $display("FAIL single_end: got busy=%b count=%0d want busy=0 count=%0d", BUSY, PKT_COUNT, mdl_cnt);
        else passes++;
    endtask

    task automatic test_round_robin();
        do_reset();
        add_pkt(0, 2, 64'h200);
        add_pkt(1, 2, 64'h210);
        add_pkt(2, 2, 64'h220);
        add_pkt(3, 2, 64'h230);
        add_pkt(0, 2, 64'h240);
        add_pkt(1, 2, 64'h250);
        build_expected();
        drive_srcs();
        repeat (17) step();
        checks++;
        if (PKT_COUNT !== 32'd5) $display("FAIL rr_count17: got %0d want 5", PKT_COUNT); else passes++;
        step();
        checks++;
        if (PKT_COUNT !== 32'd6 || !all_done())
            $display("FAIL rr_count18: got count=%0d pending=%0d want count=6 pending=0", PKT_COUNT, exp_q.size());
        else passes++;
        checks++;
        if (beat_tid.size() != 12 || beat_tid[0] != 0 || beat_tid[2] != 1 || beat_tid[4] != 2 ||
            beat_tid[6] != 3 || beat_tid[8] != 0 || beat_tid[10] != 1)
            $display("FAIL rr_order: got %0d beats, want grant order 0,1,2,3,0,1", beat_tid.size());
        else passes++;
    endtask

    task automatic test_grant_lock();
        int n;
        do_reset();
        add_pkt(1, 4, 64'h300);
        build_expected();
        drive_srcs();
        n = 0;
        while (beat_tid.size() < 2 && n < 20) begin
            step();
            n++;
        end
        add_pkt(0, 2, 64'h400);
        expect_src(0);
        SRC_ENA = 4'b1101;
        drive_srcs();
        run_to_empty(40, "lock");
        SRC_ENA = '1;
        checks++;
        if (beat_tid.size() != 6 || beat_tid[3] != 1 || beat_tid[4] != 0 || beat_cyc[4] - beat_cyc[3] != 2)
            $display("FAIL lock_bubble: got %0d beats, gap=%0d, want 6 beats with src0 starting 2 cycles after src1 last",
                     beat_tid.size(), (beat_cyc.size() == 6) ? beat_cyc[4] - beat_cyc[3] : -1);
        else passes++;
        checks++;
        if (PKT_COUNT !== mdl_cnt) $display("FAIL lock_count: got %0d want %0d", PKT_COUNT, mdl_cnt); else passes++;
    endtask

    task automatic test_alm_full_stall();
        logic [EW-1:0]    e0;
        logic [WIDTH-1:0] want;
        do_reset();
        FIFO_ALM_FULL = 1'b1;
        add_pkt(0, 3, 64'h500);
        add_pkt(3, 3, 64'h530);
        build_expected();
        drive_srcs();
        for (int k = 0; k < 3; k++) begin
            step();
            checks++;
            if (BUSY !== 1'b0 || S_AXIS_TREADY !== '0)
                $display("FAIL almfull_hold: cycle %0d got busy=%b tready=%b want 0", k, BUSY, S_AXIS_TREADY);
            else passes++;
        end
        FIFO_ALM_FULL = 1'b0;
        step();
        checks++;
        if (BUSY !== 1'b1 || M_AXIS_TID !== 2'd0)
            $display("FAIL almfull_release: got busy=%b tid=%0d want busy=1 tid=0", BUSY, M_AXIS_TID);
        else passes++;
        step();
        M_AXIS_TREADY = 1'b0;
        e0   = exp_q[0];
        want = e0[WIDTH-1:0];
        for (int k = 0; k < 5; k++) begin
            step();
            checks++;
            if (M_AXIS_TVALID !== 1'b1 || M_AXIS_TDATA !== want)
                $display("FAIL stall_stable: cycle %0d got valid=%b data=%h want valid=1 data=%h",
                         k, M_AXIS_TVALID, M_AXIS_TDATA, want);
            else passes++;
        end
        M_AXIS_TREADY = 1'b1;
        run_to_empty(40, "stall");
        checks++;
        if (beat_tid.size() != 6 || PKT_COUNT !== mdl_cnt)
            $display("FAIL stall_count: got beats=%0d count=%0d want beats=6 count=%0d", beat_tid.size(), PKT_COUNT, mdl_cnt);
        else passes++;
    endtask

    task automatic test_reset_mid_pkt();
        int n;
        do_reset();
        add_pkt(3, 5, 64'h600);
        build_expected();
        drive_srcs();
        n = 0;
        while (beat_tid.size() < 1 && n < 20) begin
            step();
            n++;
        end
        RST = 1'b1;
        step();
        checks++;
        if (BUSY !== 1'b0 || S_AXIS_TREADY !== '0 || PKT_COUNT !== 32'd0)
            $display("FAIL midreset_state: got busy=%b tready=%b count=%0d want 0,0,0", BUSY, S_AXIS_TREADY, PKT_COUNT);
        else passes++;
        RST = 1'b0;
        for (int i = 0; i < N_SRC; i++) src_q[i].delete();
        exp_q.delete();
        beat_tid.delete();
        beat_cyc.delete();
        mdl_last = ID_W'(N_SRC - 1);
        mdl_cnt  = 32'd0;
        add_pkt(3, 2, 64'h700);
        add_pkt(0, 2, 64'h710);
        build_expected();
        drive_srcs();
        run_to_empty(40, "midreset");
        checks++;
        if (beat_tid.size() != 4 || beat_tid[0] != 0 || beat_tid[2] != 3 || PKT_COUNT !== 32'd2)
            $display("FAIL midreset_order: got beats=%0d count=%0d want src0 then src3, count=2", beat_tid.size(), PKT_COUNT);
        else passes++;
    endtask

    task automatic test_count_wrap();
        do_reset();
        force dut.r_pkt_count = 32'hFFFF_FFFF;
        #1;
        release dut.r_pkt_count;
        #1;
        mdl_cnt = 32'hFFFF_FFFF;
        checks++;
        if (PKT_COUNT !== mdl_cnt) $display("FAIL wrap_preload: got %h want %h", PKT_COUNT, mdl_cnt); else passes++;
        for (int p = 0; p < 2; p++) begin
            add_pkt(1, 1, 64'h800 + WIDTH'(p));
            build_expected();
            drive_srcs();
            run_to_empty(20, "wrap");
            checks++;
            if (PKT_COUNT !== mdl_cnt) $display("FAIL wrap_count: pkt %0d got %h want %h", p, PKT_COUNT, mdl_cnt); else passes++;
        end
    endtask

    task automatic test_random();
        do_reset();
        for (int r = 0; r < 8; r++) begin
            for (int i = 0; i < N_SRC; i++) begin
                int np;
                np = int'($urandom_range(0, 3));
                for (int p = 0; p < np; p++) add_pkt(i, int'($urandom_range(1, 4)), {$urandom, $urandom});
            end
            build_expected();
            rnd = 1'b1;
            drive_srcs();
            run_to_empty(600, "random");
            rnd           = 1'b0;
            M_AXIS_TREADY = 1'b1;
            FIFO_ALM_FULL = 1'b0;
            checks++;
            if (PKT_COUNT !== mdl_cnt) $display("FAIL random_count: round %0d got %0d want %0d", r, PKT_COUNT, mdl_cnt);
            else passes++;
        end
    endtask

    initial begin
        checks        = 0;
        passes        = 0;
        cyc           = 0;
        rnd           = 1'b0;
        RST           = 1'b1;
        SRC_ENA       = '1;
        S_AXIS_TVALID = '0;
        S_AXIS_TLAST  = '0;
        S_AXIS_TDATA  = '0;
        M_AXIS_TREADY = 1'b1;
        FIFO_ALM_FULL = 1'b0;
        mdl_last      = ID_W'(N_SRC - 1);
        mdl_cnt       = 32'd0;
        test_reset();
        test_single_src();
        test_round_robin();
        test_grant_lock();
        test_alm_full_stall();
        test_reset_mid_pkt();
        test_count_wrap();
        test_random();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
